// File: rtl/memory_arbiter.sv
// memory_arbiter: shares a single-port RAM between instruction fetch (IF),
// the load/store datapath (DM) and the I/O program loader (IO).
// One transaction at a time: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
// Build option: define ARB_RR_EN for round-robin arbitration; without it
// the fixed priority DM > IF > IO applies.
module memory_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Latencies outside 1..7 collapse to a single-cycle read.
  localparam int         LAT_EFF  = ((MEM_LAT < 1) || (MEM_LAT > 7)) ? 1 : MEM_LAT;
  localparam logic [2:0] LAT_LOAD = 3'(LAT_EFF - 1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;
  localparam logic [1:0] OWN_IO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WAIT   = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  // One-hot ack vector {io, dm, if} for a given owner code.
  function automatic logic [2:0] ack_vec(input logic [1:0] own);
    logic [2:0] v;
    case (own)
      OWN_IF:  v = 3'b001;
      OWN_DM:  v = 3'b010;
      OWN_IO:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  state_e              state_q;
  logic [1:0]          owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [2:0]          ack_q;
  logic                mem_en_q;
  logic                mem_we_q;

  logic [1:0]          grant_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

`ifdef ARB_RR_EN
  // Last granted requester: 0 = IO (reset value, so IF goes first), 1 = IF, 2 = DM.
  logic [1:0] rr_q;

  // Map a granted owner onto the round-robin pointer encoding.
  function automatic logic [1:0] rr_code(input logic [1:0] own);
    logic [1:0] c;
    case (own)
      OWN_IF:  c = 2'd1;
      OWN_DM:  c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Round-robin winner: search IF -> DM -> IO cyclically, starting after the last grant.
  always_comb begin
    grant_d = OWN_NONE;
    case (rr_q)
      2'd1: begin
        if (dm_req)      grant_d = OWN_DM;
        else if (io_req) grant_d = OWN_IO;
        else if (if_req) grant_d = OWN_IF;
        else             grant_d = OWN_NONE;
      end
      2'd2: begin
        if (io_req)      grant_d = OWN_IO;
        else if (if_req) grant_d = OWN_IF;
        else if (dm_req) grant_d = OWN_DM;
        else             grant_d = OWN_NONE;
      end
      default: begin
        if (if_req)      grant_d = OWN_IF;
        else if (dm_req) grant_d = OWN_DM;
        else if (io_req) grant_d = OWN_IO;
        else             grant_d = OWN_NONE;
      end
    endcase
  end
`else
  // Fixed-priority winner: DM first, then IF, then IO.
  always_comb begin
    grant_d = OWN_NONE;
    if (dm_req)      grant_d = OWN_DM;
    else if (if_req) grant_d = OWN_IF;
    else if (io_req) grant_d = OWN_IO;
    else             grant_d = OWN_NONE;
  end
`endif

  // Route the winner's address/we/wdata toward the latches; IF is always a read.
  always_comb begin
    sel_we_d    = 1'b0;
    sel_addr_d  = {ADDR_W{1'b0}};
    sel_wdata_d = {DATA_W{1'b0}};
    case (grant_d)
      OWN_IF: begin
        sel_we_d    = 1'b0;
        sel_addr_d  = if_addr;
        sel_wdata_d = {DATA_W{1'b0}};
      end
      OWN_DM: begin
        sel_we_d    = dm_we;
        sel_addr_d  = dm_addr;
        sel_wdata_d = dm_wdata;
      end
      OWN_IO: begin
        sel_we_d    = io_we;
        sel_addr_d  = io_addr;
        sel_wdata_d = io_wdata;
      end
      default: begin
        sel_we_d    = 1'b0;
        sel_addr_d  = {ADDR_W{1'b0}};
        sel_wdata_d = {DATA_W{1'b0}};
      end
    endcase
  end

  // Transaction FSM with registered RAM controls, acks and read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      cnt_q    <= 3'd0;
      rdata_q  <= {DATA_W{1'b0}};
      ack_q    <= 3'b000;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
`ifdef ARB_RR_EN
      rr_q     <= 2'd0;
`endif
    end else begin
      // Acks and RAM strobes are single-cycle pulses unless re-asserted below.
      ack_q    <= 3'b000;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d != OWN_NONE) begin
            owner_q  <= grant_d;
            we_q     <= sel_we_d;
            addr_q   <= sel_addr_d;
            wdata_q  <= sel_wdata_d;
            mem_en_q <= 1'b1;
            mem_we_q <= sel_we_d;
            state_q  <= S_ACCESS;
`ifdef ARB_RR_EN
            rr_q     <= rr_code(grant_d);
`endif
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            ack_q   <= ack_vec(owner_q);
            state_q <= S_RESP;
          end else if (LAT_EFF == 1) begin
            rdata_q <= mem_rdata;
            ack_q   <= ack_vec(owner_q);
            state_q <= S_RESP;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            rdata_q <= mem_rdata;
            ack_q   <= ack_vec(owner_q);
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          owner_q <= OWN_NONE;
          state_q <= S_IDLE;
        end
        default: begin
          owner_q <= OWN_NONE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ack    = ack_q[0];
  assign dm_ack    = ack_q[1];
  assign io_ack    = ack_q[2];
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_memory_arbiter;

  localparam logic [1:0] OWN_IF = 2'b01;
  localparam logic [1:0] OWN_DM = 2'b10;
  localparam logic [1:0] OWN_IO = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // MEM_LAT=1 instance
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, io_req, io_we, io_ack;
  logic [15:0] if_addr, dm_addr, io_addr, mem_addr;
  logic [31:0] dm_wdata, io_wdata, rdata, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic        mem_en, mem_we;

  // MEM_LAT=3 instance
  logic        l3_if_req, l3_if_ack, l3_dm_req, l3_dm_we, l3_dm_ack, l3_io_req, l3_io_we, l3_io_ack;
  logic [15:0] l3_if_addr, l3_dm_addr, l3_io_addr, l3_mem_addr;
  logic [31:0] l3_dm_wdata, l3_io_wdata, l3_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [1:0]  l3_owner;
  logic        l3_mem_en, l3_mem_we;

  int n_tests = 0;
  int n_fail  = 0;

  int          l3_age = 0;
  logic [15:0] l3_raddr = 16'h0000;

  memory_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
    .rdata(rdata), .owner(owner), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  memory_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) u_dut_l3 (
    .clock(clock), .reset(reset),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_wdata(l3_dm_wdata), .dm_ack(l3_dm_ack),
    .io_req(l3_io_req), .io_we(l3_io_we), .io_addr(l3_io_addr), .io_wdata(l3_io_wdata), .io_ack(l3_io_ack),
    .rdata(l3_rdata), .owner(l3_owner), .mem_en(l3_mem_en), .mem_we(l3_mem_we),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
  );

  always #5 clock = ~clock;

  // RAM contents seen by both instances.
  function automatic logic [31:0] ram_f(input logic [15:0] a);
    logic [31:0] d;
    case (a)
      16'h0010: d = 32'hDEAD_BEEF;
      16'h0100: d = 32'hCAFE_F00D;
      default:  d = {16'hA5A5, a};
    endcase
    return d;
  endfunction

  function automatic logic [2:0] ack_exp(input logic [1:0] o);
    logic [2:0] v;
    case (o)
      OWN_IF:  v = 3'b001;
      OWN_DM:  v = 3'b010;
      OWN_IO:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Latency-1 RAM: combinational read while enabled, garbage otherwise.
  assign mem_rdata = (mem_en && !mem_we) ? ram_f(mem_addr) : 32'hBAD0_BAD0;

  // Latency-3 RAM: request sampled at the end of ACCESS, data valid only in the cycle before the third edge.
  always @(posedge clock) begin
    if (l3_mem_en && !l3_mem_we) begin
      l3_age   <= 1;
      l3_raddr <= l3_mem_addr;
    end else if (l3_age != 0 && l3_age < 7) begin
      l3_age <= l3_age + 1;
    end
  end
  assign l3_mem_rdata = (l3_age == 2) ? ram_f(l3_raddr) : 32'hBAD0_BAD0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Follow one MEM_LAT=1 transaction whose grant edge is the next rising edge.
  task automatic expect_txn(input string tag, input logic [1:0] own, input logic we,
                            input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input bit drop_early);
    @(posedge clock); #1;
    check_val({tag, "_owner"}, 64'(owner), 64'(own));
    check_val({tag, "_en"}, 64'(mem_en), 64'd1);
    check_val({tag, "_we"}, 64'(mem_we), 64'(we));
    check_val({tag, "_addr"}, 64'(mem_addr), 64'(addr));
    if (we) check_val({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
    if (drop_early) begin
      if_req = 1'b0; dm_req = 1'b0; io_req = 1'b0;
    end
    @(posedge clock); #1;
    check_val({tag, "_ack"}, 64'({io_ack, dm_ack, if_ack}), 64'(ack_exp(own)));
    check_val({tag, "_en_off"}, 64'({mem_en, mem_we}), 64'd0);
    check_val({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
    @(posedge clock); #1;
    check_val({tag, "_idle"}, 64'({owner, io_ack, dm_ack, if_ack}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, if_cnt, dm_cnt, io_cnt, en_cnt, multi;
    bit got;
    if_addr = 16'h0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 32'h0;
    io_we = 1'b0; io_addr = 16'h0; io_wdata = 32'h0;
    l3_if_addr = 16'h0; l3_dm_we = 1'b0; l3_dm_addr = 16'h0; l3_dm_wdata = 32'h0;
    l3_io_we = 1'b0; l3_io_addr = 16'h0; l3_io_wdata = 32'h0;

    // Reset held with every request asserted
    if_req = 1'b1; dm_req = 1'b1; io_req = 1'b1;
    l3_if_req = 1'b1; l3_dm_req = 1'b1; l3_io_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check_val("rst_ctl", 64'({owner, io_ack, dm_ack, if_ack, mem_en, mem_we}), 64'd0);
      check_val("rst_l3_ctl", 64'({l3_owner, l3_io_ack, l3_dm_ack, l3_if_ack, l3_mem_en, l3_mem_we}), 64'd0);
    end
    check_val("rst_bus", 64'({mem_addr, rdata}), 64'd0);
    check_val("rst_wdata", 64'(mem_wdata), 64'd0);
    if_req = 1'b0; dm_req = 1'b0; io_req = 1'b0;
    l3_if_req = 1'b0; l3_dm_req = 1'b0; l3_io_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("idle_after_rst", 64'({owner, mem_en}), 64'd0);

    // Single IF read
    if_addr = 16'h0010; if_req = 1'b1;
    expect_txn("if_rd", OWN_IF, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    if_req = 1'b0;

    // IF and DM store arrive together, fresh from reset
    reset = 1'b0; #1; reset = 1'b1;
    dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 32'h1234_5678;
    if_req = 1'b1; dm_req = 1'b1;
`ifdef ARB_RR_EN
    expect_txn("rr_if_first", OWN_IF, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    if_req = 1'b0;
    expect_txn("rr_dm_second", OWN_DM, 1'b1, 16'h0020, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    dm_req = 1'b0;
`else
    expect_txn("fx_dm_first", OWN_DM, 1'b1, 16'h0020, 32'h1234_5678, 32'h0, 1'b0);
    dm_req = 1'b0;
    expect_txn("fx_if_second", OWN_IF, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    if_req = 1'b0;
`endif

    // IO write leaves rdata untouched; DM load whose req drops right after grant
    io_we = 1'b1; io_addr = 16'h0040; io_wdata = 32'h0BAD_C0DE; io_req = 1'b1;
    expect_txn("io_wr", OWN_IO, 1'b1, 16'h0040, 32'h0BAD_C0DE, 32'hDEAD_BEEF, 1'b0);
    io_req = 1'b0;
    dm_we = 1'b0; dm_addr = 16'h0050; dm_req = 1'b1;
    expect_txn("dm_rd_drop", OWN_DM, 1'b0, 16'h0050, 32'h0, 32'hA5A5_0050, 1'b1);

    // MEM_LAT=3 DM load
    l3_dm_we = 1'b0; l3_dm_addr = 16'h0100; l3_dm_req = 1'b1;
    @(posedge clock); #1;
    check_val("l3_grant", 64'({l3_owner, l3_mem_en, l3_mem_we}), 64'({OWN_DM, 1'b1, 1'b0}));
    check_val("l3_addr", 64'(l3_mem_addr), 64'h0100);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      check_val("l3_dm_ack_timing", 64'({l3_io_ack, l3_dm_ack, l3_if_ack}), (k == 3) ? 64'd2 : 64'd0);
      check_val("l3_en_once", 64'(l3_mem_en), 64'd0);
    end
    check_val("l3_rdata", 64'(l3_rdata), 64'hCAFE_F00D);
    l3_dm_req = 1'b0;
    @(posedge clock); #1;
    check_val("l3_idle", 64'({l3_owner, l3_dm_ack}), 64'd0);

    // Reset during WAIT of an IO read, then reissue
    l3_io_we = 1'b0; l3_io_addr = 16'h0030; l3_io_req = 1'b1;
    @(posedge clock); #1;
    check_val("l3_io_grant", 64'(l3_owner), 64'(OWN_IO));
    @(posedge clock); #1;
    check_val("l3_io_wait", 64'({l3_owner, l3_io_ack}), 64'({OWN_IO, 1'b0}));
    #1 reset = 1'b0;
    #1;
    check_val("l3_rst_async", 64'({l3_owner, l3_io_ack, l3_mem_en}), 64'd0);
    @(posedge clock); #1;
    check_val("l3_rst_noack", 64'({l3_owner, l3_io_ack}), 64'd0);
    reset = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 12 && !got) begin
      @(posedge clock); #1;
      cyc++;
      if (l3_io_ack) got = 1'b1;
    end
    check_val("l3_reissue_ack", 64'(got), 64'd1);
    check_val("l3_reissue_lat", 64'(cyc), 64'd4);
    check_val("l3_reissue_rdata", 64'(l3_rdata), 64'hA5A5_0030);
    l3_io_req = 1'b0;
    @(posedge clock); #1;

    // Continuous traffic from all three requesters, ten transactions
    reset = 1'b0; #1; reset = 1'b1;
    dm_we = 1'b0; io_we = 1'b0; if_addr = 16'h0010; dm_addr = 16'h0050; io_addr = 16'h0060;
    if_req = 1'b1; dm_req = 1'b1; io_req = 1'b1;
    if_cnt = 0; dm_cnt = 0; io_cnt = 0; en_cnt = 0; multi = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock); #1;
      if_cnt += int'(if_ack);
      dm_cnt += int'(dm_ack);
      io_cnt += int'(io_ack);
      en_cnt += int'(mem_en);
      if ((int'(if_ack) + int'(dm_ack) + int'(io_ack)) > 1) multi++;
    end
    if_req = 1'b0; dm_req = 1'b0; io_req = 1'b0;
    check_val("load_en_count", 64'(en_cnt), 64'd10);
    check_val("load_one_ack", 64'(multi), 64'd0);
`ifdef ARB_RR_EN
    check_val("load_rr_if", 64'(if_cnt), 64'd4);
    check_val("load_rr_dm", 64'(dm_cnt), 64'd3);
    check_val("load_rr_io", 64'(io_cnt), 64'd3);
`else
    check_val("load_fx_if", 64'(if_cnt), 64'd0);
    check_val("load_fx_dm", 64'(dm_cnt), 64'd10);
    check_val("load_fx_io", 64'(io_cnt), 64'd0);
`endif
    repeat (4) @(posedge clock);
    #1;
    check_val("final_idle", 64'({owner, mem_en}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
